// File: rtl/rxcea_pkg.sv
// Shared definitions for the rxcea receive/transmit frame path: FSM states,
// CRC-16/MODBUS constants and single-bit CRC step.
package rxcea_pkg;

   typedef enum logic [2:0] {
      S_ID1  = 3'd0,
      S_ID2  = 3'd1,
      S_CNT1 = 3'd2,
      S_CNT2 = 3'd3,
      S_DATA = 3'd4,
      S_CRC1 = 3'd5,
      S_CRC2 = 3'd6
   } rx_state_e;

   localparam logic [15:0] CRC16_POLY = 16'hA001;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   localparam int FRAME_HDR_LEN = 4;
   localparam int FRAME_CRC_LEN = 2;

   // One reflected shift/xor step of CRC-16/MODBUS.
   function automatic logic [15:0] crc16_shift(input logic [15:0] crc);
      logic [15:0] res;
      if (crc[0]) begin
         res = (crc >> 1) ^ CRC16_POLY;
      end else begin
         res = crc >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/rxcea_frame_parser_if.sv
// Byte-in / command-out bus between the UART receiver, the frame parser and
// the transmit-frame generator.
interface rxcea_frame_parser_if;
   import rxcea_pkg::*;

   logic [7:0] rx_data;
   logic       rx_data_flag;
   logic [7:0] cmd;
   logic       cmd_flag;
   logic       frame_err;

   modport master (
      output rx_data, rx_data_flag,
      input  cmd, cmd_flag, frame_err
   );

   modport slave (
      input  rx_data, rx_data_flag,
      output cmd, cmd_flag, frame_err
   );

endinterface

// File: rtl/rxcea_frame_parser_crc16_byte_upd.sv
// Combinational CRC-16/MODBUS update by one byte (8 unrolled steps); also used
// by the transmit-frame generator.
module crc16_byte_upd
   import rxcea_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  byte_in,
   output logic [15:0] crc_out
);

   logic [15:0] stage_s [0:8];

   assign stage_s[0] = crc_in ^ {8'h00, byte_in};

   for (genvar g = 0; g < 8; g++) begin : g_step
      assign stage_s[g+1] = crc16_shift(stage_s[g]);
   end

   assign crc_out = stage_s[8];

endmodule

// File: rtl/rxcea_frame_parser.sv
// Receive-frame parser: ID1 ID2 CNT1 CNT2 PAYLOAD CRC1 CRC2 -> cmd pulse.
// Define CRC_CHECK_EN to enable CRC comparison; otherwise CRC bytes are only consumed.
module rxcea_frame_parser
   import rxcea_pkg::*;
#(
   parameter logic [15:0] DEV_ID      = 16'h0001,
   parameter int          MAX_LEN     = 16,
   parameter int          TIMEOUT_CYC = 50000
)(
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   rxcea_frame_parser_if.slave   bus
);

   localparam int TO_W = $clog2(TIMEOUT_CYC);

   rx_state_e   state_r, state_nxt_s;
   logic [15:0] len_r, len_nxt_s;
   logic [15:0] cnt_r, cnt_nxt_s;
   logic [7:0]  cmd_buf_r, cmd_buf_nxt_s;
   logic [7:0]  cmd_r, cmd_nxt_s;
   logic        cmd_flag_r, cmd_flag_nxt_s;
   logic        frame_err_r, frame_err_nxt_s;
   logic [TO_W-1:0] to_cnt_r;
   logic        timeout_s;
   logic        crc_ok_s;

   // A byte landing in the expiry cycle wins over the timeout.
   assign timeout_s = (state_r != S_ID1) && !bus.rx_data_flag &&
                      (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

`ifdef CRC_CHECK_EN
   logic [15:0] crc_r;
   logic [15:0] crc_upd_s;
   logic [7:0]  crc_rx_hi_r;

   crc16_byte_upd u_crc (
      .crc_in  (crc_r),
      .byte_in (bus.rx_data),
      .crc_out (crc_upd_s)
   );

   assign crc_ok_s = ({crc_rx_hi_r, bus.rx_data} == crc_r);

   // Running CRC over ID1..last payload byte; reinitialised whenever we head back to S_ID1.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         crc_r <= CRC16_INIT;
      end else if (state_nxt_s == S_ID1) begin
         crc_r <= CRC16_INIT;
      end else if (bus.rx_data_flag && (state_r <= S_DATA)) begin
         crc_r <= crc_upd_s;
      end else begin
         crc_r <= crc_r;
      end
   end

   // Received CRC high byte.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         crc_rx_hi_r <= 8'h00;
      end else if (bus.rx_data_flag && (state_r == S_CRC1)) begin
         crc_rx_hi_r <= bus.rx_data;
      end else begin
         crc_rx_hi_r <= crc_rx_hi_r;
      end
   end
`else
   assign crc_ok_s = 1'b1;
`endif

   // Inter-byte idle counter.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         to_cnt_r <= '0;
      end else if (bus.rx_data_flag || (state_r == S_ID1) || timeout_s) begin
         to_cnt_r <= '0;
      end else begin
         to_cnt_r <= to_cnt_r + 1'b1;
      end
   end

   // Next-state and datapath decode; outputs are pulses by default.
   always_comb begin
      state_nxt_s     = state_r;
      len_nxt_s       = len_r;
      cnt_nxt_s       = cnt_r;
      cmd_buf_nxt_s   = cmd_buf_r;
      cmd_nxt_s       = cmd_r;
      cmd_flag_nxt_s  = 1'b0;
      frame_err_nxt_s = 1'b0;
      if (bus.rx_data_flag) begin
         case (state_r)
            S_ID1: begin
               if (bus.rx_data == DEV_ID[15:8]) state_nxt_s = S_ID2;
               else                              state_nxt_s = S_ID1;
            end
            S_ID2: begin
               if (bus.rx_data == DEV_ID[7:0]) state_nxt_s = S_CNT1;
               else                             state_nxt_s = S_ID1;
            end
            S_CNT1: begin
               len_nxt_s   = {bus.rx_data, 8'h00};
               state_nxt_s = S_CNT2;
            end
            S_CNT2: begin
               len_nxt_s = {len_r[15:8], bus.rx_data};
               cnt_nxt_s = 16'h0000;
               if ((len_nxt_s == 16'h0000) || (len_nxt_s > 16'(MAX_LEN))) begin
                  frame_err_nxt_s = 1'b1;
                  state_nxt_s     = S_ID1;
               end else begin
                  state_nxt_s = S_DATA;
               end
            end
            S_DATA: begin
               if (cnt_r == 16'h0000) cmd_buf_nxt_s = bus.rx_data;
               else                   cmd_buf_nxt_s = cmd_buf_r;
               cnt_nxt_s = cnt_r + 16'd1;
               if (cnt_nxt_s == len_r) state_nxt_s = S_CRC1;
               else                    state_nxt_s = S_DATA;
            end
            S_CRC1: begin
               state_nxt_s = S_CRC2;
            end
            S_CRC2: begin
               if (crc_ok_s) begin
                  cmd_nxt_s      = cmd_buf_r;
                  cmd_flag_nxt_s = 1'b1;
               end else begin
                  frame_err_nxt_s = 1'b1;
               end
               state_nxt_s = S_ID1;
            end
            default: begin
               state_nxt_s = S_ID1;
            end
         endcase
      end else if (timeout_s) begin
         frame_err_nxt_s = 1'b1;
         state_nxt_s     = S_ID1;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_r     <= S_ID1;
         len_r       <= 16'h0000;
         cnt_r       <= 16'h0000;
         cmd_buf_r   <= 8'h00;
         cmd_r       <= 8'h00;
         cmd_flag_r  <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         len_r       <= len_nxt_s;
         cnt_r       <= cnt_nxt_s;
         cmd_buf_r   <= cmd_buf_nxt_s;
         cmd_r       <= cmd_nxt_s;
         cmd_flag_r  <= cmd_flag_nxt_s;
         frame_err_r <= frame_err_nxt_s;
      end
   end

   assign bus.cmd       = cmd_r;
   assign bus.cmd_flag  = cmd_flag_r;
   assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_rxcea_frame_parser.sv
// Scoreboard bench for rxcea_frame_parser: directed frames push expected
// pulses (kind, cmd, cycle) into a queue; a monitor pops and compares.
module tb_rxcea_frame_parser;

   localparam int TO = 40;

   typedef struct {
      int         kind;   // 1 = cmd_flag, 2 = frame_err
      logic [7:0] cmd;
      int         cyc;
   } exp_t;

   logic sys_clk;
   logic sys_rst;
   int   cyc;
   int   pass_cnt;
   int   total_cnt;
   logic [7:0] model_cmd;
   logic [7:0] tx_q [$];
   exp_t       exp_q [$];
   exp_t       mon_e;
   int         act_kind;

   rxcea_frame_parser_if bus ();

   rxcea_frame_parser #(
      .DEV_ID      (16'h0001),
      .MAX_LEN     (16),
      .TIMEOUT_CYC (TO)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic logic [15:0] crc_model();
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (tx_q[i]) begin
         c = c ^ {8'h00, tx_q[i]};
         for (int b = 0; b < 8; b++) begin
            if (c[0]) c = (c >> 1) ^ 16'hA001;
            else      c = c >> 1;
         end
      end
      return c;
   endfunction

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data      = b;
      bus.rx_data_flag = 1'b1;
      @(negedge sys_clk);
      bus.rx_data_flag = 1'b0;
      bus.rx_data      = 8'h00;
   endtask

   task automatic build_frame(input int len, input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input bit bad);
      logic [15:0] c;
      tx_q.delete();
      tx_q.push_back(8'h00);
      tx_q.push_back(8'h01);
      tx_q.push_back(8'(len >> 8));
      tx_q.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
         if (i == 0)      tx_q.push_back(p0);
         else if (i == 1) tx_q.push_back(p1);
         else if (i == 2) tx_q.push_back(p2);
         else             tx_q.push_back(8'(i));
      end
      c = crc_model();
      tx_q.push_back(c[15:8]);
      tx_q.push_back(bad ? (c[7:0] ^ 8'hFF) : c[7:0]);
   endtask

   // Sends tx_q; before byte dec_idx pushes the expected pulse lat cycles out.
   task automatic send_q(input int gap, input int kind, input int dec_idx, input int lat,
                         input int slow_idx, input int slow_gap);
      exp_t e;
      for (int i = 0; i < tx_q.size(); i++) begin
         if ((i == dec_idx) && (kind != 0)) begin
            if (kind == 1) model_cmd = tx_q[4];
            e.kind = kind;
            e.cmd  = model_cmd;
            e.cyc  = cyc + lat;
            exp_q.push_back(e);
         end
         send_byte(tx_q[i]);
         idle((i == slow_idx) ? slow_gap : gap);
      end
   endtask

   // Monitor: every output pulse must match the head of the expectation queue.
   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         if (bus.cmd_flag || bus.frame_err) begin
            total_cnt++;
            if (bus.cmd_flag && bus.frame_err) begin
               $display("FAIL both_pulses: cmd_flag=1 frame_err=1 at cyc %0d, required not both", cyc);
            end else if (exp_q.size() == 0) begin
               $display("FAIL unexpected_pulse: cmd_flag=%b frame_err=%b cmd=%h at cyc %0d, required none",
                        bus.cmd_flag, bus.frame_err, bus.cmd, cyc);
            end else begin
               mon_e    = exp_q.pop_front();
               act_kind = bus.cmd_flag ? 1 : 2;
               if ((act_kind == mon_e.kind) && (bus.cmd === mon_e.cmd) && (cyc == mon_e.cyc)) begin
                  pass_cnt++;
               end else begin
                  $display("FAIL pulse: kind=%0d cmd=%h cyc=%0d, required kind=%0d cmd=%h cyc=%0d",
                           act_kind, bus.cmd, cyc, mon_e.kind, mon_e.cmd, mon_e.cyc);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      cyc              = 0;
      pass_cnt         = 0;
      total_cnt        = 0;
      model_cmd        = 8'h00;
      bus.rx_data      = 8'h00;
      bus.rx_data_flag = 1'b0;
      sys_rst          = 1'b1;

      tx_q.delete();
      for (int i = 0; i < 9; i++) tx_q.push_back(8'h31 + 8'(i));
      if (crc_model() !== 16'h4B37) begin
         $display("FAIL crc_model: got %h expected 4b37", crc_model());
         $fatal(1);
      end

      #2 sys_rst = 1'b0;
      #1;
      chk8("rst_cmd", bus.cmd, 8'h00);
      chk8("rst_cmd_flag", {7'd0, bus.cmd_flag}, 8'h00);
      chk8("rst_frame_err", {7'd0, bus.frame_err}, 8'h00);
      idle(3);
      sys_rst = 1'b1;
      idle(2);

      // 1: good frame, 10-cycle gaps
      build_frame(1, 8'h5A, 8'h00, 8'h00, 1'b0);
      send_q(10, 1, tx_q.size() - 1, 1, -1, 0);

      // 2: corrupted CRC low byte
      build_frame(1, 8'h5A, 8'h00, 8'h00, 1'b1);
`ifdef CRC_CHECK_EN
      send_q(2, 2, tx_q.size() - 1, 1, -1, 0);
`else
      send_q(2, 1, tx_q.size() - 1, 1, -1, 0);
`endif

      // 3: zero length and over-length headers, then a good frame
      tx_q.delete();
      tx_q.push_back(8'h00); tx_q.push_back(8'h01); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
      send_q(1, 2, 3, 1, -1, 0);
      tx_q.delete();
      tx_q.push_back(8'h00); tx_q.push_back(8'h01); tx_q.push_back(8'h00); tx_q.push_back(8'h11);
      send_q(1, 2, 3, 1, -1, 0);
      build_frame(1, 8'h42, 8'h00, 8'h00, 1'b0);
      send_q(1, 1, tx_q.size() - 1, 1, -1, 0);

      // 4: garbage resync, then three-byte payload
      tx_q.delete();
      tx_q.push_back(8'h33); tx_q.push_back(8'h00); tx_q.push_back(8'h02);
      send_q(1, 0, -1, 1, -1, 0);
      build_frame(3, 8'hA5, 8'hB6, 8'hC7, 1'b0);
      send_q(1, 1, tx_q.size() - 1, 1, -1, 0);

      // 5: timeout after CNT2, then a byte exactly in the expiry cycle
      tx_q.delete();
      tx_q.push_back(8'h00); tx_q.push_back(8'h01); tx_q.push_back(8'h00); tx_q.push_back(8'h01);
      send_q(1, 2, 3, TO + 1, 3, TO + 5);
      build_frame(1, 8'h99, 8'h00, 8'h00, 1'b0);
      send_q(1, 1, tx_q.size() - 1, 1, 3, TO - 1);

      // 6: reset mid-payload, recovery, back-to-back frames
      build_frame(5, 8'h77, 8'h88, 8'h66, 1'b0);
      for (int i = 0; i < 6; i++) begin
         send_byte(tx_q[i]);
         idle(1);
      end
      sys_rst = 1'b0;
      #1;
      model_cmd = 8'h00;
      chk8("midrst_cmd", bus.cmd, 8'h00);
      chk8("midrst_cmd_flag", {7'd0, bus.cmd_flag}, 8'h00);
      chk8("midrst_frame_err", {7'd0, bus.frame_err}, 8'h00);
      idle(2);
      sys_rst = 1'b1;
      idle(2);
      build_frame(1, 8'h3C, 8'h00, 8'h00, 1'b0);
      send_q(1, 1, tx_q.size() - 1, 1, -1, 0);
      build_frame(1, 8'h11, 8'h00, 8'h00, 1'b0);
      send_q(0, 1, tx_q.size() - 1, 1, -1, 0);
      build_frame(1, 8'h22, 8'h00, 8'h00, 1'b0);
      send_q(0, 1, tx_q.size() - 1, 1, -1, 0);

      idle(6);
      chk8("pending_expectations", 8'(exp_q.size()), 8'h00);
      chk8("final_cmd", bus.cmd, 8'h22);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
